// File: rtl/dh_run_ctrl.sv
// Bus front end for full_mat: holds the DH table, sequences one flush+run+capture
// pass on command and keeps the captured end-effector matrix for readback.
module dh_run_ctrl #(
  parameter int DATA_W     = 27,
  parameter int N_JOINT    = 6,
  parameter int RUN_CYCLES = 90
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 write,
  input  logic                                 read,
  input  logic [5:0]                           address,
  input  logic [31:0]                          writedata,
  output logic [31:0]                          readdata,
  output logic                                 irq,
  output logic                                 fm_rst,
  output logic                                 fm_en,
  output logic [N_JOINT-1:0][3:0][DATA_W-1:0]  dh_param,
  input  logic [3:0][3:0][DATA_W-1:0]          full_matrix
);

  localparam int EXT_W = 32 - DATA_W;

  typedef enum logic [1:0] {IDLE, FLUSH, RUN, CAPTURE} state_t;

  state_t                              state_q, state_d;
  logic [6:0]                          cnt_q, cnt_d;
  logic                                done_q, done_d;
  logic                                fm_rst_q, fm_rst_d;
  logic                                fm_en_q, fm_en_d;
  logic [31:0]                         readdata_q, readdata_d;
  logic [N_JOINT-1:0][3:0][DATA_W-1:0] dh_q, dh_d;
  logic [3:0][3:0][DATA_W-1:0]         res_q, res_d;

  logic        busy;
  logic        is_dh;
  logic        ctrl_wr;
  logic        start;
  logic        clr;
  logic [31:0] rd_val;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = done_q;
    fm_rst_d   = fm_rst_q;
    fm_en_d    = fm_en_q;
    readdata_d = readdata_q;
    dh_d       = dh_q;
    res_d      = res_q;
    rd_val     = 32'd0;

    busy    = (state_q != IDLE);
    is_dh   = (address < 6'd24);
    ctrl_wr = write && (address == 6'd24);
    start   = ctrl_wr && writedata[0];
    clr     = ctrl_wr && writedata[1];

    // The table is frozen while busy so full_mat sees constant parameters all run.
    if (write && is_dh && !busy)
      dh_d[address[4:2]][address[1:0]] = writedata[DATA_W-1:0];

    if (is_dh)
      rd_val = {{EXT_W{dh_q[address[4:2]][address[1:0]][DATA_W-1]}},
                dh_q[address[4:2]][address[1:0]]};
    else if (address == 6'd25)
      rd_val = {30'd0, done_q, busy};
    else if (address[5:4] == 2'b10)
      rd_val = {{EXT_W{res_q[address[3:2]][address[1:0]][DATA_W-1]}},
                res_q[address[3:2]][address[1:0]]};

    if (read)
      readdata_d = rd_val;

    case (state_q)
      IDLE: begin
        fm_rst_d = 1'b0;
        fm_en_d  = 1'b0;
        if (start) begin
          state_d  = FLUSH;
          cnt_d    = 7'd0;
          done_d   = 1'b0;
          fm_rst_d = 1'b1;
        end
      end
      FLUSH: begin
        state_d  = RUN;
        fm_rst_d = 1'b0;
        fm_en_d  = 1'b1;
      end
      RUN: begin
        if (cnt_q == 7'(RUN_CYCLES - 1)) begin
          state_d = CAPTURE;
          fm_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      CAPTURE: begin
        state_d = IDLE;
        res_d   = full_matrix;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (clr && !(start && !busy))
      done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 7'd0;
      done_q     <= 1'b0;
      fm_rst_q   <= 1'b0;
      fm_en_q    <= 1'b0;
      readdata_q <= 32'd0;
      dh_q       <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      fm_rst_q   <= fm_rst_d;
      fm_en_q    <= fm_en_d;
      readdata_q <= readdata_d;
      dh_q       <= dh_d;
      res_q      <= res_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = done_q;
  assign fm_rst   = fm_rst_q;
  assign fm_en    = fm_en_q;
  assign dh_param = dh_q;

endmodule

// File: tb/tb_dh_run_ctrl.sv
// Bench for dh_run_ctrl: directed register/run scenarios followed by random bus
// traffic, all checked against a cycle-count based model of the controller.
module tb_dh_run_ctrl;

  typedef logic [5:0][3:0][26:0] dh_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [5:0]  address = 6'd0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        irq;
  logic        fm_rst;
  logic        fm_en;
  dh_t         dh_param;
  logic [3:0][3:0][26:0] full_matrix = '0;

  int errors = 0;
  int checks = 0;

  // Model: runK counts edges since the accepted start (-1 when idle).
  logic [26:0] refDh[24];
  logic [26:0] refRes[16];
  logic        refDone = 1'b0;
  logic [31:0] refRd = 32'd0;
  int          runK = -1;
  int          edgeNo = 0;
  int          enCount = 0;
  int          rstCount = 0;

  dh_run_ctrl dut (
    .clk(clk), .rst_n(rst_n), .write(write), .read(read), .address(address),
    .writedata(writedata), .readdata(readdata), .irq(irq), .fm_rst(fm_rst),
    .fm_en(fm_en), .dh_param(dh_param), .full_matrix(full_matrix)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [647:0] observed,
                             input logic [647:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] sext27(input logic [26:0] v);
    int s;
    s = int'(v);
    if (s >= (1 << 26)) s = s - (1 << 27);
    return 32'(s);
  endfunction

  function automatic logic [31:0] modelRead(input int a);
    if (a < 24) return sext27(refDh[a]);
    if (a == 25) return {30'd0, refDone, (runK >= 0)};
    if (a >= 32 && a < 48) return sext27(refRes[a - 32]);
    return 32'd0;
  endfunction

  function automatic dh_t expDh();
    dh_t e;
    for (int j = 0; j < 6; j++)
      for (int p = 0; p < 4; p++)
        e[j][p] = refDh[j * 4 + p];
    return e;
  endfunction

  task automatic compareAll();
    checkOutput("ctl", {irq, fm_rst, fm_en},
                {refDone, (runK == 0), (runK >= 1 && runK <= 90)});
    checkOutput("rdata", readdata, refRd);
    checkOutput("dh", dh_param, expDh());
    enCount  += int'(fm_en);
    rstCount += int'(fm_rst);
  endtask

  task automatic applyStimulus(input bit w, input bit r, input int a, input logic [31:0] d);
    bit busy, start, clr;
    @(negedge clk);
    write = w; read = r; address = a[5:0]; writedata = d;
    @(posedge clk);
    edgeNo++;
    busy = (runK >= 0);
    start = 1'b0;
    clr = 1'b0;
    if (r) refRd = modelRead(a);
    if (w) begin
      if (a < 24 && !busy) refDh[a] = d[26:0];
      if (a == 24) begin
        start = d[0] && !busy;
        clr   = d[1];
      end
    end
    if (runK >= 0) begin
      runK++;
      if (runK == 92) begin
        for (int i = 0; i < 16; i++) refRes[i] = full_matrix[i / 4][i % 4];
        refDone = 1'b1;
        runK = -1;
      end
    end
    if (clr) refDone = 1'b0;
    if (start) begin
      runK = 0;
      refDone = 1'b0;
    end
    #1 compareAll();
  endtask

  task automatic resetDut();
    @(negedge clk);
    #2;
    write = 1'b0; read = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_ctl", {irq, fm_rst, fm_en}, 3'b000);
    checkOutput("rst_rdata", readdata, 32'd0);
    checkOutput("rst_dh", dh_param, 648'd0);
    for (int i = 0; i < 24; i++) refDh[i] = '0;
    for (int i = 0; i < 16; i++) refRes[i] = '0;
    refDone = 1'b0; refRd = 32'd0; runK = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic runToDone(input int budget);
    int i;
    i = 0;
    while (!irq && i < budget) begin
      applyStimulus(0, 0, 0, 0);
      i++;
    end
    checkOutput("done_timeout", irq, 1'b1);
  endtask

  initial begin
    int e0;
    int op, a;
    logic [26:0] saved00;

    for (int i = 0; i < 24; i++) refDh[i] = '0;
    for (int i = 0; i < 16; i++) refRes[i] = '0;

    resetDut();
    for (int i = 0; i < 48; i++) begin
      applyStimulus(0, 1, i, 0);
      checkOutput("rd_reset", readdata, 32'd0);
    end

    applyStimulus(1, 0, 5, 32'h07FF_FFFF);
    applyStimulus(1, 0, 23, 32'h0400_0000);
    checkOutput("dh11", dh_param[1][1], 27'h7FF_FFFF);
    applyStimulus(0, 1, 5, 0);
    checkOutput("rd5", readdata, 32'hFFFF_FFFF);
    applyStimulus(0, 1, 23, 0);
    checkOutput("rd23", readdata, 32'hFC00_0000);

    for (int i = 0; i < 24; i++) applyStimulus(1, 0, i, $urandom);
    full_matrix = '0;
    for (int i = 0; i < 4; i++) full_matrix[i][i] = 27'h010_0000;
    enCount = 0; rstCount = 0;
    applyStimulus(1, 0, 24, 32'd1);
    e0 = edgeNo;
    saved00 = refDh[0];
    for (int i = 1; i < 150 && !irq; i++) begin
      if (i == 10) applyStimulus(1, 0, 0, ~{5'd0, saved00});
      else if (i == 11) applyStimulus(1, 0, 24, 32'd1);
      else if (i == 12) begin
        applyStimulus(0, 1, 25, 0);
        checkOutput("status_busy", readdata, 32'd1);
        checkOutput("dh00_frozen", dh_param[0][0], saved00);
      end else applyStimulus(0, 0, 0, 0);
    end
    checkOutput("irq_edge", edgeNo - e0, 92);
    checkOutput("en_count", enCount, 90);
    checkOutput("rst_count", rstCount, 1);
    applyStimulus(0, 1, 32, 0);
    checkOutput("res00", readdata, 32'h0010_0000);
    applyStimulus(0, 1, 33, 0);
    checkOutput("res01", readdata, 32'd0);

    applyStimulus(1, 0, 24, 32'd2);
    checkOutput("irq_clr", irq, 1'b0);
    applyStimulus(0, 1, 25, 0);
    checkOutput("status_idle", readdata, 32'd0);
    applyStimulus(1, 0, 24, 32'd1);
    runToDone(150);
    applyStimulus(1, 0, 24, 32'd3);
    checkOutput("irq_start_clr", irq, 1'b0);
    applyStimulus(0, 1, 25, 0);
    checkOutput("status_restart", readdata, 32'd1);
    runToDone(150);

    applyStimulus(1, 0, 24, 32'd1);
    repeat (41) applyStimulus(0, 0, 0, 0);
    resetDut();
    applyStimulus(0, 1, 25, 0);
    checkOutput("status_after_rst", readdata, 32'd0);
    enCount = 0;
    applyStimulus(1, 0, 24, 32'd1);
    runToDone(150);
    checkOutput("en_count_after_rst", enCount, 90);

    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 49) == 0)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) full_matrix[i][j] = 27'($urandom);
      op = int'($urandom_range(0, 9));
      a  = int'($urandom_range(0, 63));
      case (op)
        4, 5: applyStimulus(1, 0, int'($urandom_range(0, 23)), $urandom);
        6:    applyStimulus(1, 0, 24, {30'd0, 2'($urandom)});
        7, 8: applyStimulus(0, 1, a, 0);
        9:    applyStimulus(1, 1, a, $urandom);
        default: applyStimulus(0, 0, 0, 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dh_run_ctrl.md
# dh_run_ctrl

Bus-facing front end for the `full_mat` forward-kinematics pipeline. It holds the six-joint DH parameter table written by software, sequences one complete 90-cycle `full_mat` run on command, and captures the resulting 4×4 end-effector matrix for readback. It drives `full_mat`'s `rst`, `en` and `dh_param` inputs, and it consumes `full_matrix`.

## Interface
Parameters:
- `DATA_W`, 27: fixed-point word width of the DH and matrix entries.
- `N_JOINT`, 6: number of joints; also the DH table depth.
- `RUN_CYCLES`, 90: number of `en` cycles in one `full_mat` pass. This equals `full_mat` `MAX`.

Ports:
- `clk`, in, 1: the only clock. All logic is on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `write`, in, 1: bus write strobe. Each cycle the strobe is high is one write.
- `read`, in, 1: bus read strobe.
- `address`, in, 6: word address.
- `writedata`, in, 32: write data.
- `readdata`, out, 32: registered read data.
- `irq`, out, 1: level interrupt. It equals the sticky `done` flag.
- `fm_rst`, out, 1: synchronous active-high reset to `full_mat`.
- `fm_en`, out, 1: enable to `full_mat`.
- `dh_param`, out, [5:0][3:0][26:0]: the DH table, indexed [joint][param]. Param order is θ=0, a=1, d=2, α=3.
- `full_matrix`, in, [3:0][3:0][26:0]: the `full_mat` result, indexed [row][col].

## Operation
Address map:
- 0–23: DH entry `dh_param[addr/4][addr%4]`.
  - Write stores `writedata[26:0]`.
  - Read returns that entry sign-extended to 32 bits.
- 24: CTRL. These are write-only actions; a read returns 0.
  - bit0=1: start.
  - bit1=1: clear `done`.
- 25: STATUS, read-only. bit0=busy, bit1=done; other bits are 0.
- 32–47: RESULT `res[(addr-32)/4][(addr-32)%4]`, sign-extended. Read-only.
- Any other address: writes are ignored and reads return 0.

State machine (IDLE → FLUSH → RUN → CAPTURE → IDLE):
- IDLE: `fm_rst=0`, `fm_en=0`, busy=0. A CTRL write with bit0=1 does three things: it clears `done`, zeroes `cnt`, and goes to FLUSH.
- FLUSH: one cycle with `fm_rst=1`, `fm_en=0`. Then go to RUN.
- RUN: `fm_en=1` and `cnt` increments each cycle. After the cycle with `cnt==RUN_CYCLES-1`, go to CAPTURE.
- CAPTURE: one cycle with `fm_en=0`. At the end of this cycle `res` ← `full_matrix` and `done` ← 1. Then go to IDLE.

Busy rules (busy = state ≠ IDLE):
- DH writes are ignored while busy, so `dh_param` is stable for the whole run.
- A start is ignored while busy.
- A clear-`done` is accepted in any state.
- If start and clear arrive in the same write, start wins and `done` ends at 0.

Other rules:
- `res` keeps its previous contents until the next CAPTURE.
- Arithmetic: none. Values pass through bit-exact; readback sign-extends bit 26.
- `cnt` is 7 bits and never wraps: RUN exits at `RUN_CYCLES-1`.

## Timing
- Reset (`rst_n`=0, asynchronous) clears everything: state=IDLE, `cnt`=0, `dh_param`=0, `res`=0, `done`=0, `readdata`=0, `irq`=0, `fm_rst`=0, `fm_en`=0.
- Reset mid-run aborts immediately. `res` returns to 0 and no `done` is raised.
- Reads:
  - `readdata` is valid on the cycle after `read` is sampled and holds until the next read.
  - When no read is sampled, `readdata` keeps its value.
  - A simultaneous read and write to the same DH address returns the old value.
- Run timing, with the start write sampled at edge E0:
  - `fm_rst`=1 during cycle E0→E1.
  - `fm_en`=1 for exactly `RUN_CYCLES` consecutive cycles, E1→E(RUN_CYCLES+1).
  - CAPTURE runs during E(RUN_CYCLES+1)→E(RUN_CYCLES+2). `res`, `done` and `irq` are updated at E(RUN_CYCLES+2), which is 92 cycles after E0 with defaults.
- busy reads 1 from E0+1 through E(RUN_CYCLES+2), inclusive of the capture edge's cycle. A new start is accepted from the cycle after `done` rises.

## Test plan
1. Reset, then read all 48 mapped/result addresses → every read returns 0; `fm_en`=0, `fm_rst`=0, `irq`=0.
2. Write 0x7FFFFFF to address 5 and 0x4000000 to address 23, then read them back:
   - `dh_param[1][1]`=0x7FFFFFF and address 5 reads 0xFFFFFFFF.
   - Address 23 reads 0xFC000000.
3. Load the DH table, write CTRL=1 at E0, and drive `full_matrix` with the identity in Q-format (1.0=0x0100000):
   - `fm_rst` is high for exactly 1 cycle.
   - `fm_en` is high for exactly 90 cycles.
   - `irq` rises at E0+92.
   - Address 32 reads 0x00100000; address 33 reads 0.
4. During RUN:
   - Write address 0 → `dh_param[0][0]` is unchanged.
   - Write CTRL=1 again → `fm_en` pulse count stays 90.
   - STATUS reads 0x1.
5. After `done`:
   - Write CTRL=2 → `irq`=0 and STATUS reads 0.
   - Write CTRL=3 in a fresh done state → a run starts and `done`=0.
6. Deassert `rst_n` at RUN cycle 40 → all outputs are 0 asynchronously. After release, STATUS reads 0 and a new start yields a full 90-cycle `fm_en` burst.
